// File: rtl/result_reader_pkg.sv
// result_reader shared package: opcodes, FSM state type, header helper.
// Optional header word is enabled with RESULT_READER_HEADER_EN.
package result_reader_pkg;

  localparam logic [3:0] START_CAL   = 4'h1;
  localparam logic [3:0] WRITE_VEC   = 4'h2;
  localparam logic [3:0] WRITE_MAT   = 4'h4;
  localparam logic [3:0] READ_RESULT = 4'h6;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    FIN
  } rr_state_e;

  // Header word announcing a readback of cnt words.
  function automatic logic [15:0] hdr_word(input logic [7:0] cnt);
    return {READ_RESULT, 4'h0, cnt};
  endfunction

endpackage

// File: rtl/result_reader_cmd_edge_detect.sv
// cmd_edge_detect: 2-flop synchroniser / shift register on the SPI
// word strobe with a single-cycle rising-edge pulse.
module cmd_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic [1:0] sr_q;

  // Shift the strobe in; older sample in bit 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_q <= 2'b00;
    else       sr_q <= {sr_q[0], sig_i};
  end

  assign rise_o = (sr_q == 2'b01);

endmodule

// File: rtl/result_reader.sv
// result_reader: decodes READ_RESULT, fetches result words from memory
// and streams them over valid/ready. Header option: RESULT_READER_HEADER_EN.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_data,
  input  logic [ADDR_SIZE-1:0] result_base,
  output logic                 r_en,
  output logic [ADDR_SIZE-1:0] r_addr,
  input  logic [WORD_SIZE-1:0] r_data,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  rr_state_e            state_q;
  logic [7:0]           cnt_q;
  logic [7:0]           idx_q;
  logic [ADDR_SIZE-1:0] base_q;
  logic                 r_en_q;
  logic [ADDR_SIZE-1:0] r_addr_q;
  logic [WORD_SIZE-1:0] tx_data_q;
  logic                 tx_valid_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef RESULT_READER_HEADER_EN
  logic                 hdr_q;
`endif

  logic       cmd_det;
  logic       is_rd;
  logic       last_w;
  logic [7:0] idx_d;
  logic       unused_cmd;

  cmd_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (cmd_valid),
    .rise_o (cmd_det)
  );

  assign is_rd      = cmd_det && (cmd_data[15:12] == READ_RESULT);
  assign idx_d      = idx_q + 8'd1;
  assign last_w     = (idx_q == cnt_q - 8'd1);
  assign unused_cmd = ^cmd_data[11:8];

  // Readback FSM; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      base_q     <= '0;
      r_en_q     <= 1'b0;
      r_addr_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RESULT_READER_HEADER_EN
      hdr_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (is_rd) begin
            cnt_q  <= cmd_data[7:0];
            base_q <= result_base;
            idx_q  <= '0;
            busy_q <= 1'b1;
`ifdef RESULT_READER_HEADER_EN
            tx_data_q  <= WORD_SIZE'(hdr_word(cmd_data[7:0]));
            tx_valid_q <= 1'b1;
            hdr_q      <= 1'b1;
            state_q    <= SEND;
`else
            if (cmd_data[7:0] == 8'd0) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              r_en_q   <= 1'b1;
              r_addr_q <= result_base;
              state_q  <= FETCH;
            end
`endif
          end
        end
        FETCH: begin
          r_en_q  <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          tx_data_q  <= r_data;
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
`ifdef RESULT_READER_HEADER_EN
            if (hdr_q) begin
              hdr_q <= 1'b0;
              if (cnt_q == 8'd0) begin
                done_q  <= 1'b1;
                state_q <= FIN;
              end else begin
                r_en_q   <= 1'b1;
                r_addr_q <= base_q;
                state_q  <= FETCH;
              end
            end else
`endif
            begin
              idx_q <= idx_d;
              if (last_w) begin
                done_q  <= 1'b1;
                state_q <= FIN;
              end else begin
                r_en_q   <= 1'b1;
                r_addr_q <= base_q + ADDR_SIZE'(idx_d);
                state_q  <= FETCH;
              end
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_en     = r_en_q;
  assign r_addr   = r_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: directed + randomized readbacks checked against a
// word-list / timing reference model.
module tb_result_reader;

`ifdef RESULT_READER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic [9:0]  result_base;
  logic        r_en;
  logic [9:0]  r_addr;
  logic [15:0] r_data = '0;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int nchk = 0;
  int nerr = 0;

  logic [15:0] mem [1024];

  result_reader dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .result_base (result_base),
    .r_en        (r_en),
    .r_addr      (r_addr),
    .r_data      (r_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (r_en) r_data <= mem[r_addr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One readback: builds the expected transmit list, then checks every
  // cycle against spec timing (fetch, +2 valid, next fetch after accept).
  task automatic run_read(input logic [9:0] base, input logic [15:0] cmd,
                          input int stall0, input bit rnd,
                          input bit inject, input int rst_word);
    logic [15:0] ew[$];
    bit          ef[$];
    logic [9:0]  ea[$];
    logic [9:0]  a;
    logic [7:0]  cnt;
    int n, it, k, fcyc, vstart, done_cyc, stall_left, rst_item;
    bit e_ren, e_val;
    cnt = cmd[7:0];
    if (HDR == 1) begin
      ew.push_back({4'h6, 4'h0, cnt});
      ef.push_back(1'b0);
      ea.push_back(10'h0);
    end
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 10'(i);
      ea.push_back(a);
      ew.push_back(mem[a]);
      ef.push_back(1'b1);
    end
    n = ew.size();
    it = 0;
    k = 0;
    fcyc = -1;
    vstart = 1 << 20;
    stall_left = stall0;
    rst_item = (rst_word < 0) ? -1 : rst_word + HDR;
    done_cyc = (n == 0) ? 1 : (1 << 20);
    if (n > 0) begin
      fcyc   = ef[0] ? 1 : -1;
      vstart = ef[0] ? 3 : 1;
    end
    result_base = base;
    cmd_data = cmd;
    cmd_valid = 1'b1;
    tx_ready = 1'b1;
    step();
    chk("idle_at_detect", busy, 1'b0);
    for (int g = 0; g < 3000 && k <= done_cyc + 1; g++) begin
      step();
      k++;
      if (k == 1) cmd_valid = 1'b0;
      if (inject && k == 4) begin
        cmd_data = 16'h6002;
        cmd_valid = 1'b1;
      end
      if (inject && k == 6) cmd_valid = 1'b0;
      e_ren = (it < n) && (k == fcyc);
      e_val = (it < n) && (k >= vstart);
      if (it == rst_item && e_val) begin
        reset = 1'b1;
        #1;
        chk("rst_r_en", r_en, 1'b0);
        chk("rst_r_addr", r_addr, 10'h0);
        chk("rst_tx_data", tx_data, 16'h0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        step();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
          step();
          chk("post_rst_done", done, 1'b0);
          chk("post_rst_busy", busy, 1'b0);
        end
        return;
      end
      chk("r_en", r_en, e_ren);
      if (e_ren) chk("r_addr", r_addr, ea[it]);
      chk("tx_valid", tx_valid, e_val);
      if (e_val) chk("tx_data", tx_data, ew[it]);
      chk("done", done, k == done_cyc);
      chk("busy", busy, k <= done_cyc);
      if (it == HDR && e_val && stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (e_val && tx_ready) begin
        it++;
        if (it < n) begin
          fcyc   = ef[it] ? k + 1 : -1;
          vstart = ef[it] ? k + 3 : k + 1;
        end else begin
          done_cyc = k + 1;
        end
      end
    end
    chk("readback_completed", k > done_cyc + 1, 1'b1);
    tx_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    result_base = '0;
    tx_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    step();
    step();
    chk("reset_r_en", r_en, 1'b0);
    chk("reset_r_addr", r_addr, 10'h0);
    chk("reset_tx_data", tx_data, 16'h0);
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    reset = 1'b0;
    step();
    step();

    run_read(10'h010, 16'h6003, 0, 1'b0, 1'b0, -1);
    run_read(10'h123, 16'h6002, 5, 1'b0, 1'b0, -1);
    run_read(10'h200, 16'h6000, 0, 1'b0, 1'b0, -1);
    run_read(10'h3FE, 16'h6004, 0, 1'b0, 1'b0, -1);

    cmd_data = 16'h4005;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ign_busy", busy, 1'b0);
      chk("ign_r_en", r_en, 1'b0);
      chk("ign_tx_valid", tx_valid, 1'b0);
      chk("ign_done", done, 1'b0);
    end
    cmd_valid = 1'b0;
    step();
    step();

    run_read(10'h050, 16'h6003, 0, 1'b0, 1'b1, -1);
    run_read(10'h0A0, 16'h6004, 0, 1'b0, 1'b0, 1);
    run_read(10'h0B0, 16'h6001, 0, 1'b0, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      logic [15:0] c;
      c = {4'h6, 4'($urandom), 8'($urandom_range(0, 8))};
      run_read(10'($urandom), c, $urandom_range(0, 3), 1'b1, 1'b0, -1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
